// File: rtl/hazard_scoreboard.sv
// Hazard controller for a 5-stage RV32 pipeline: forwarding, load-use, multi-cycle E tracking.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic              use1D,
    input  logic              use2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              validE,
    input  logic              regwriteE,
    input  logic              is_loadE,
    input  logic              is_mcE,
    input  logic              pc_redirectE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              perf_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              mc_start,
    output logic              mc_done,
    output logic [CNT_W-1:0]  ld_stall_cnt,
    output logic [CNT_W-1:0]  mc_stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mc_state_t;

    localparam logic [7:0] MC_LAST = 8'(MC_LAT - 1);

    mc_state_t  r_state;
    mc_state_t  w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_mc_start_raw;
    logic       w_mc_done_raw;
    logic       w_mcstall_raw;
    logic       w_ldhaz;
    logic       w_mcstall;
    logic       w_ld_stall;
    logic       w_redirect;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave it unassigned and infer a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mc_start_raw = 1'b0;
        w_mc_done_raw  = 1'b0;
        w_mcstall_raw  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (validE && is_mcE) begin
                    w_mc_start_raw = 1'b1;
                    w_mcstall_raw  = 1'b1;
                    w_state_nxt    = S_BUSY;
                    w_cnt_nxt      = 8'd1;
                end
            end
            S_BUSY: begin
                if (r_cnt < MC_LAST) begin
                    w_mcstall_raw = 1'b1;
                    w_cnt_nxt     = r_cnt + 8'd1;
                end else begin
                    w_mc_done_raw = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = 8'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
        // A redirect squashes whatever E holds, including an in-flight multi-cycle op.
        if (pc_redirectE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 8'd0;
        end
    end

    always_comb begin
        w_ldhaz = validE && is_loadE && regwriteE && (rdE != '0) &&
                  ((use1D && (rs1D == rdE)) || (use2D && (rs2D == rdE)));
        w_redirect = !rst && pc_redirectE;
        w_mcstall  = !rst && !pc_redirectE && w_mcstall_raw;
        w_ld_stall = !rst && !pc_redirectE && !w_mcstall_raw && w_ldhaz;
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (rs1E != '0) begin
                if (regwriteM && (rdM == rs1E))      ForwardAE = 2'b01;
                else if (regwriteW && (rdW == rs1E)) ForwardAE = 2'b10;
            end
            if (rs2E != '0) begin
                if (regwriteM && (rdM == rs2E))      ForwardBE = 2'b01;
                else if (regwriteW && (rdW == rs2E)) ForwardBE = 2'b10;
            end
        end
    end

    assign StallF   = w_mcstall || w_ld_stall;
    assign StallD   = w_mcstall || w_ld_stall;
    assign StallE   = w_mcstall;
    assign FlushD   = rst || w_redirect;
    assign FlushE   = rst || w_redirect || w_ld_stall;
    assign FlushM   = rst || w_mcstall;
    assign mc_start = !rst && !pc_redirectE && w_mc_start_raw;
    assign mc_done  = !rst && !pc_redirectE && w_mc_done_raw;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_ld_cnt;
    logic [CNT_W-1:0] r_mc_cnt;
    logic [CNT_W-1:0] r_rd_cnt;

    // Counters stick at all-ones; a clear in the same cycle discards the increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            r_ld_cnt <= '0;
            r_mc_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_ld_stall && (r_ld_cnt != '1)) r_ld_cnt <= r_ld_cnt + 1'b1;
            if (w_mcstall  && (r_mc_cnt != '1)) r_mc_cnt <= r_mc_cnt + 1'b1;
            if (w_redirect && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    assign ld_stall_cnt = r_ld_cnt;
    assign mc_stall_cnt = r_mc_cnt;
    assign redirect_cnt = r_rd_cnt;
`else
    logic w_perf_clr_unused;
    assign w_perf_clr_unused = perf_clr;
    assign ld_stall_cnt      = '0;
    assign mc_stall_cnt      = '0;
    assign redirect_cnt      = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic              use1D, use2D, validE, regwriteE, is_loadE, is_mcE;
    logic              pc_redirectE, regwriteM, regwriteW, perf_clr;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic              mc_start, mc_done;
    logic [CNT_W-1:0]  ld_stall_cnt, mc_stall_cnt, redirect_cnt;

    hazard_scoreboard #(
        .REG_AW(REG_AW),
        .MC_LAT(MC_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .use1D(use1D), .use2D(use2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .validE(validE), .regwriteE(regwriteE), .is_loadE(is_loadE), .is_mcE(is_mcE),
        .pc_redirectE(pc_redirectE),
        .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .perf_clr(perf_clr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .mc_start(mc_start), .mc_done(mc_done),
        .ld_stall_cnt(ld_stall_cnt), .mc_stall_cnt(mc_stall_cnt), .redirect_cnt(redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: cycles the current mc op has already spent in E (0 = none in flight).
    int m_age = 0;
    int m_ld = 0, m_mc = 0, m_rd = 0;
    int n_age, n_ld, n_mc, n_rd;

    function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (regwriteM && rdM == rs) return 2'b01;
        if (regwriteW && rdW == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v, input bit inc);
        if (!inc || v == CNT_MAX) return v;
        return v + 1;
    endfunction

    task automatic idle_inputs();
        rst = 0; rs1D = 0; rs2D = 0; use1D = 0; use2D = 0;
        rs1E = 0; rs2E = 0; rdE = 0; validE = 0; regwriteE = 0; is_loadE = 0; is_mcE = 0;
        pc_redirectE = 0; rdM = 0; rdW = 0; regwriteM = 0; regwriteW = 0; perf_clr = 0;
    endtask

    // Compare every output against the model for the current inputs, then prepare next state.
    task automatic eval_cycle(input string tag);
        bit ldhaz, busy, starting, mcst, fin, redir;
        bit e_sf, e_se, e_fd, e_fe, e_fm, e_st, e_dn;
        logic [1:0] e_fa, e_fb;
        #2;
        ldhaz = validE && is_loadE && regwriteE && rdE != 0 &&
                ((use1D && rs1D == rdE) || (use2D && rs2D == rdE));
        busy     = (m_age > 0);
        starting = !busy && validE && is_mcE;
        mcst     = starting || (busy && m_age < MC_LAT - 1);
        fin      = busy && (m_age == MC_LAT - 1);
        redir    = pc_redirectE;
        if (rst) begin
            e_fa = 0; e_fb = 0; e_sf = 0; e_se = 0;
            e_fd = 1; e_fe = 1; e_fm = 1; e_st = 0; e_dn = 0;
        end else begin
            e_fa = exp_fwd(rs1E);
            e_fb = exp_fwd(rs2E);
            e_sf = !redir && (mcst || ldhaz);
            e_se = !redir && mcst;
            e_fd = redir;
            e_fe = redir || (ldhaz && !mcst);
            e_fm = !redir && mcst;
            e_st = !redir && starting;
            e_dn = !redir && fin;
        end
        check({tag, ".fwdA"},   32'(ForwardAE), 32'(e_fa));
        check({tag, ".fwdB"},   32'(ForwardBE), 32'(e_fb));
        check({tag, ".stallF"}, 32'(StallF), 32'(e_sf));
        check({tag, ".stallD"}, 32'(StallD), 32'(e_sf));
        check({tag, ".stallE"}, 32'(StallE), 32'(e_se));
        check({tag, ".flushD"}, 32'(FlushD), 32'(e_fd));
        check({tag, ".flushE"}, 32'(FlushE), 32'(e_fe));
        check({tag, ".flushM"}, 32'(FlushM), 32'(e_fm));
        check({tag, ".start"},  32'(mc_start), 32'(e_st));
        check({tag, ".done"},   32'(mc_done), 32'(e_dn));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".ldcnt"}, 32'(ld_stall_cnt), 32'(m_ld));
        check({tag, ".mccnt"}, 32'(mc_stall_cnt), 32'(m_mc));
        check({tag, ".rdcnt"}, 32'(redirect_cnt), 32'(m_rd));
`else
        check({tag, ".ldcnt"}, 32'(ld_stall_cnt), 32'd0);
        check({tag, ".mccnt"}, 32'(mc_stall_cnt), 32'd0);
        check({tag, ".rdcnt"}, 32'(redirect_cnt), 32'd0);
`endif
        if (rst || redir)  n_age = 0;
        else if (starting) n_age = 1;
        else if (busy)     n_age = fin ? 0 : m_age + 1;
        else               n_age = 0;
        if (rst || perf_clr) begin
            n_ld = 0; n_mc = 0; n_rd = 0;
        end else begin
            n_ld = sat_inc(m_ld, ldhaz && !mcst && !redir);
            n_mc = sat_inc(m_mc, mcst && !redir);
            n_rd = sat_inc(m_rd, redir);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_age = n_age; m_ld = n_ld; m_mc = n_mc; m_rd = n_rd;
        #1;
    endtask

    initial begin
        idle_inputs();
        @(posedge clk); #1;

        // Reset: forwarding candidates present but outputs must stay quiet.
        rst = 1; rs1E = 5; rdM = 5; regwriteM = 1;
        for (int i = 0; i < 2; i++) begin
            eval_cycle("rst");
            check("rst.fwdA0", 32'(ForwardAE), 32'd0);
            check("rst.flushM1", 32'(FlushM), 32'd1);
            tick();
        end
        idle_inputs();

        // Forwarding priority M > W, and x0 never forwards.
        rs1E = 5; regwriteM = 1; rdM = 5; regwriteW = 1; rdW = 5;
        eval_cycle("fwd_mw"); check("fwd_m", 32'(ForwardAE), 32'd1); tick();
        regwriteM = 0;
        eval_cycle("fwd_w");  check("fwd_w", 32'(ForwardAE), 32'd2); tick();
        rs1E = 0;
        eval_cycle("fwd_0");  check("fwd_0", 32'(ForwardAE), 32'd0); tick();
        idle_inputs();

        // Load-use: lw x7 in E, add x8,x7,x1 in D.
        validE = 1; is_loadE = 1; regwriteE = 1; rdE = 7; rs1D = 7; rs2D = 1; use1D = 1; use2D = 1;
        eval_cycle("lu");
        check("lu_stallF", 32'(StallF), 32'd1);
        check("lu_flushE", 32'(FlushE), 32'd1);
        tick();
        idle_inputs();
        validE = 1; regwriteE = 1; rdE = 8; rs1E = 7; rs2E = 1; regwriteW = 1; rdW = 7;
        rs1D = 3; use1D = 1;
        eval_cycle("lu_next");
        check("lu_fwdW", 32'(ForwardAE), 32'd2);
        check("lu_nostall", 32'(StallF), 32'd0);
        tick();
        idle_inputs();

        // Redirect together with load-use: redirect wins.
        validE = 1; is_loadE = 1; regwriteE = 1; rdE = 9; rs2D = 9; use2D = 1; pc_redirectE = 1;
        eval_cycle("rdlu");
        check("rdlu_stallF", 32'(StallF), 32'd0);
        check("rdlu_flushD", 32'(FlushD), 32'd1);
        check("rdlu_flushE", 32'(FlushE), 32'd1);
        tick();
        idle_inputs();

        // Back-to-back muls, second one aborted by reset at cnt=2.
        validE = 1; is_mcE = 1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) rst = 1;
            eval_cycle($sformatf("mul%0d", c));
            if (c == 0 || c == 4) check($sformatf("mul%0d_start", c), 32'(mc_start), 32'd1);
            if (c >= 1 && c <= 2) check($sformatf("mul%0d_stallE", c), 32'(StallE), 32'd1);
            if (c == 3) begin
                check("mul3_done", 32'(mc_done), 32'd1);
                check("mul3_nostall", 32'(StallF), 32'd0);
            end
            if (c == 6) check("mul6_rst_stallE", 32'(StallE), 32'd0);
            tick();
        end
        idle_inputs();
        eval_cycle("post_rst"); check("post_rst_stallE", 32'(StallE), 32'd0); tick();
        validE = 1; is_mcE = 1;
        for (int c = 0; c < MC_LAT; c++) begin
            eval_cycle($sformatf("remul%0d", c));
            check($sformatf("remul%0d_stallF", c), 32'(StallF), 32'(c < MC_LAT - 1));
            check($sformatf("remul%0d_done", c), 32'(mc_done), 32'(c == MC_LAT - 1));
            tick();
        end
        idle_inputs();

`ifdef HAZARD_PERF_CNT_EN
        perf_clr = 1; eval_cycle("pclr0"); tick(); perf_clr = 0;
        validE = 1; is_mcE = 1;
        for (int c = 0; c < 27; c++) begin eval_cycle("sat"); tick(); end
        idle_inputs();
        eval_cycle("sat_end"); check("mc_cnt_sat", 32'(mc_stall_cnt), 32'(CNT_MAX)); tick();
        perf_clr = 1; eval_cycle("pclr1"); tick(); perf_clr = 0;
        eval_cycle("pclr_after"); check("mc_cnt_clr", 32'(mc_stall_cnt), 32'd0); tick();
`else
        eval_cycle("nocnt");
        check("nocnt_ld", 32'(ld_stall_cnt), 32'd0);
        check("nocnt_mc", 32'(mc_stall_cnt), 32'd0);
        check("nocnt_rd", 32'(redirect_cnt), 32'd0);
        tick();
`endif

        // Random traffic with small register indices to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 39) == 0);
            perf_clr     = ($urandom_range(0, 29) == 0);
            rs1D         = REG_AW'($urandom_range(0, 3));
            rs2D         = REG_AW'($urandom_range(0, 3));
            rs1E         = REG_AW'($urandom_range(0, 3));
            rs2E         = REG_AW'($urandom_range(0, 3));
            rdE          = REG_AW'($urandom_range(0, 3));
            rdM          = REG_AW'($urandom_range(0, 3));
            rdW          = REG_AW'($urandom_range(0, 3));
            use1D        = 1'($urandom);
            use2D        = 1'($urandom);
            validE       = ($urandom_range(0, 3) != 0);
            regwriteE    = 1'($urandom);
            is_loadE     = 1'($urandom);
            is_mcE       = ($urandom_range(0, 5) == 0);
            pc_redirectE = ($urandom_range(0, 9) == 0);
            regwriteM    = 1'($urandom);
            regwriteW    = 1'($urandom);
            eval_cycle($sformatf("rnd%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard controller for the 5-stage RV32 pipeline. It extends plain forwarding and load-use handling with a sequential multi-cycle execute tracker for MUL/DIV-class ops that occupy E for MC_LAT cycles. It also adds optional saturating hazard performance counters. It sits beside the pipeline registers and drives the operand-forward muxes and the stall/flush controls of F, D, E and M.

## Interface
- REG_AW, 5, register-index width (2**REG_AW architectural registers; index 0 is hard-wired zero).
- MC_LAT, 4, cycles a multi-cycle op occupies E; legal range 2..255.
- CNT_W, 32, perf-counter width.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rs1D, rs2D  in  REG_AW  decode-stage source indices.
- use1D, use2D  in  1  decode instruction actually reads rs1/rs2.
- rs1E, rs2E, rdE  in  REG_AW  execute-stage indices.
- validE, regwriteE, is_loadE, is_mcE  in  1  execute-stage qualifiers.
- pc_redirectE  in  1  taken branch/jump resolved in E.
- rdM, rdW  in  REG_AW; regwriteM, regwriteW  in  1  later-stage writers.
- perf_clr  in  1  synchronous clear of perf counters.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ALUResultM, 10 = ResultW.
- StallF, StallD, StallE  out  1  hold the PC or the pipeline register.
- FlushD, FlushE, FlushM  out  1  load a bubble into the pipeline register.
- mc_start  out  1  one-cycle pulse; the multi-cycle unit captures its operands this cycle.
- mc_done  out  1  one-cycle pulse; the multi-cycle result is valid in E this cycle.
- ld_stall_cnt, mc_stall_cnt, redirect_cnt  out  CNT_W  performance counters.

## Operation
- **Forwarding (per operand, index ≠ 0):**
  - If regwriteM and rdM matches, select 01.
  - Otherwise, if regwriteW and rdW matches, select 10.
  - Otherwise select 00.
  - M has priority over W.
- **Load-use:** ldhaz = validE & is_loadE & regwriteE & rdE≠0 & ((use1D & rs1D==rdE) | (use2D & rs2D==rdE)).
  - Effect: StallF=1, StallD=1, FlushE=1.
- **Multi-cycle FSM:** states IDLE and BUSY, with a counter cnt of width 8.
  - IDLE, when validE & is_mcE:
    - assert mc_start and mcstall;
    - next state BUSY, cnt←1.
  - BUSY, when cnt < MC_LAT−1:
    - assert mcstall;
    - cnt←cnt+1.
  - BUSY, when cnt == MC_LAT−1:
    - assert mc_done, no stall;
    - next state IDLE, cnt←0.
  - The op occupies E for exactly MC_LAT cycles. A back-to-back mc op starts again in IDLE on the next cycle.
- **mcstall effect:** StallF=1, StallD=1, StallE=1, FlushM=1 (bubbles into M).
- **Redirect:** pc_redirectE gives FlushD=1 and FlushE=1, and forces StallF=0 and StallD=0 (the PC must load the target).
- **Priority:** redirect > mcstall > ldhaz.
  - While mcstall is high, ldhaz must not raise FlushE; E holds the mc op.
  - Redirect cannot coincide with mcstall, because a branch is never an mc op. If it does, redirect wins and the FSM returns to IDLE.
- **Reset:** state IDLE, cnt 0, counters 0.
  - While rst=1: FlushD, FlushE, FlushM = 1; all Stall* = 0; Forward* = 00; mc_start = mc_done = 0.

## Timing
- Forward, stall, flush, mc_start and mc_done are combinational from the same-cycle inputs plus registered state. There is no added pipeline latency.
- The FSM and counters update on the rising edge of clk.
- A load-use stall lasts exactly one cycle. The loaded value then forwards from W (10).
- An mc result reaches M in the cycle after mc_done and forwards from there (01).
- rst asserted mid-BUSY aborts the op; the FSM is IDLE in the next cycle.

## Configuration
- **HAZARD_PERF_CNT_EN defined:**
  - ld_stall_cnt increments each cycle ldhaz stalls.
  - mc_stall_cnt increments each cycle mcstall=1.
  - redirect_cnt increments each cycle pc_redirectE=1.
  - All counters saturate at 2**CNT_W−1.
  - perf_clr or rst zeroes them; an increment in the same cycle as perf_clr is discarded.
- **Undefined:** counter registers are not built; the three outputs are tied to 0 and perf_clr is ignored.

## Test plan
- **Forwarding priority:** rs1E=5, regwriteM=1, rdM=5, regwriteW=1, rdW=5 -> ForwardAE=01. Then regwriteM=0 -> ForwardAE=10. Then rs1E=0 -> 00.
- **Load-use:** E holds lw x7 and D holds add x8,x7,x1 (use1D=1) -> StallF=StallD=FlushE=1 for one cycle. Next cycle: ForwardAE=10 and no stall.
- **MC_LAT=4, mul in E:**
  - mc_start in cycle 0;
  - StallF, StallD, StallE and FlushM high in cycles 0–2;
  - mc_done in cycle 3 with no stall;
  - a second mul following immediately produces mc_start in cycle 4.
- **Simultaneous redirect and load-use:** pc_redirectE=1 with ldhaz true -> FlushD=FlushE=1, StallF=StallD=0.
- **Reset mid-BUSY:** rst=1 at cnt=2 -> the following cycle is IDLE with no stall. A new mul gets a full 4-cycle occupancy.
- **With HAZARD_PERF_CNT_EN and CNT_W=4:**
  - 20 mc-stall cycles -> mc_stall_cnt=15 (saturated);
  - perf_clr -> 0 next cycle;
  - macro undefined -> all counters read 0.
